// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point FFT frame loader.
package fft_pkg;

    localparam int FFT_POINTS = 4;
    localparam int CPLX_W     = 32;

    typedef logic signed [CPLX_W-1:0] cplx_t;
    typedef cplx_t [FFT_POINTS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RELEASE
    } ctrl_t;

    function automatic logic [1:0] bitrev2(input logic [1:0] k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 4-slot sample bank with a full flag; the loader instantiates two for ping-pong buffering.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             we,
    input  logic [1:0]                       addr,
    input  logic [WIDTH-1:0]                 wdata,
    input  logic                             set_full,
    input  logic                             clr_full,
    output logic                             full,
    output logic [FFT_POINTS-1:0][WIDTH-1:0] data
);

    logic [FFT_POINTS-1:0][WIDTH-1:0] data_q, data_d;
    logic                             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (we) begin
            data_d[addr] = wdata;
        end
        if (clr_full) begin
            full_d = 1'b0;
        end
        if (set_full) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader and control sequencer for the 4-point FFT core.
// Define FFT_LOADER_BITREV_EN to store each frame in bit-reversed slot order.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [WIDTH-1:0]                 s_data,
    output logic [FFT_POINTS-1:0][WIDTH-1:0] frame_out,
    output logic                             fft_start,
    output logic                             fft_reset,
    input  logic                             fft_status,
    output logic                             frame_done,
    output logic [CNT_W-1:0]                 frame_count
);

    logic [1:0]                       idx_q, idx_d;
    logic                             wr_bank_q, wr_bank_d;
    logic                             rd_bank_q, rd_bank_d;
    ctrl_t                            state_q, state_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [FFT_POINTS-1:0][WIDTH-1:0] frame_q, frame_d;

    logic                             accept;
    logic [1:0]                       wr_addr;
    logic                             releasing;
    logic [1:0]                       full;
    logic [1:0]                       bank_we;
    logic [1:0]                       bank_set;
    logic [1:0]                       bank_clr;
    logic [FFT_POINTS-1:0][WIDTH-1:0] bank_data [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]  = accept && (wr_bank_q == 1'(b));
        assign bank_set[b] = bank_we[b] && (idx_q == 2'd3);
        assign bank_clr[b] = releasing && (rd_bank_q == 1'(b));

        fft_frame_bank #(
            .WIDTH(WIDTH)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (bank_we[b]),
            .addr    (wr_addr),
            .wdata   (s_data),
            .set_full(bank_set[b]),
            .clr_full(bank_clr[b]),
            .full    (full[b]),
            .data    (bank_data[b])
        );
    end

    // Gated by reset_n so nothing is accepted while reset is asserted.
    assign s_ready = reset_n && !full[wr_bank_q];
    assign accept  = s_valid && s_ready;

    always_comb begin
`ifdef FFT_LOADER_BITREV_EN
        wr_addr = bitrev2(idx_q);
`else
        wr_addr = idx_q;
`endif
        idx_d     = accept ? idx_q + 2'd1 : idx_q;
        wr_bank_d = (accept && idx_q == 2'd3) ? !wr_bank_q : wr_bank_q;
    end

    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        count_d    = count_q;
        frame_d    = frame_q;
        fft_start  = 1'b0;
        fft_reset  = 1'b0;
        frame_done = 1'b0;
        releasing  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full[rd_bank_q]) begin
                    // Snapshot the bank so frame_out holds still through the whole FFT.
                    frame_d = bank_data[rd_bank_q];
                    state_d = START;
                end
            end
            START: begin
                fft_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (fft_status) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                fft_reset  = 1'b1;
                frame_done = 1'b1;
                releasing  = 1'b1;
                count_d    = count_q + 1'b1;
                rd_bank_d  = !rd_bank_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            state_q   <= IDLE;
            count_q   <= '0;
            frame_q   <= '0;
        end else begin
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            state_q   <= state_d;
            count_q   <= count_d;
            frame_q   <= frame_d;
        end
    end

    assign frame_out   = frame_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader (CNT_W=4 to exercise counter wrap).
module tb_fft_frame_loader;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH-1:0]       s_data;
    logic [3:0][WIDTH-1:0]  frame_out;
    logic                   fft_start;
    logic                   fft_reset;
    logic                   fft_status;
    logic                   frame_done;
    logic [CNT_W-1:0]       frame_count;

    int errors = 0;
    int checks = 0;

    fft_frame_loader #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .frame_out  (frame_out),
        .fft_start  (fft_start),
        .fft_reset  (fft_reset),
        .fft_status (fft_status),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = !clk;

    // Which input sample index (within a frame) lands in slot s.
    function automatic int slot_src(input int s);
`ifdef FFT_LOADER_BITREV_EN
        return (s == 1) ? 2 : (s == 2) ? 1 : s;
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        fft_status = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Sends four samples; on return the current cycle is the one after the last accept.
    task automatic send4(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                         input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3,
                         output int accepted);
        logic [WIDTH-1:0] vals [4];
        vals = '{v0, v1, v2, v3};
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 4; c++) begin
            s_valid = 1'b1;
            s_data  = vals[accepted];
            if (s_ready) accepted++;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (fft_start) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    // Streams n samples with a status responder; reports frames, bad snapshots, accepts.
    task automatic run_stream(input int n, input int lat, output int done, output int starts,
                              output int bad, output int sent);
        int cd;
        int target;
        cd     = -1;
        done   = 0;
        starts = 0;
        bad    = 0;
        sent   = 0;
        target = n / 4;
        for (int c = 0; c < 4000 && done < target; c++) begin
            s_valid = (sent < n);
            s_data  = {16'(sent + 16'h100), 16'(sent)};
            if (s_valid && s_ready) sent++;
            if (cd > 0) cd--;
            if (cd == 0) begin
                fft_status = 1'b1;
                cd = -1;
            end
            if (fft_start) begin
                for (int s = 0; s < 4; s++) begin
                    int e;
                    e = starts * 4 + slot_src(s);
                    if (frame_out[s] !== {16'(e + 16'h100), 16'(e)}) bad++;
                end
                starts++;
                cd = lat;
            end
            if (fft_reset) fft_status = 1'b0;
            if (frame_done) done++;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        s_valid    = 1'b1;
        s_data     = 32'hDEAD_BEEF;
        fft_status = 1'b0;
        tick();
        tick();
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL reset_s_ready got=%b want=0", s_ready);
        end
        checks++;
        if ({fft_start, fft_reset, frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got=%b want=000",
                               {fft_start, fft_reset, frame_done});
        end
        checks++;
        if (frame_count !== '0) begin
            errors++; $display("FAIL reset_count got=%0d want=0", frame_count);
        end
        checks++;
        if (frame_out !== '0) begin
            errors++; $display("FAIL reset_frame_out got=%h want=0", frame_out);
        end
        s_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_s_ready got=%b want=1", s_ready);
        end
    endtask

    task automatic test_basic_frame();
        logic [WIDTH-1:0] vals [4];
        int acc;
        vals = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        apply_reset();
        send4(vals[0], vals[1], vals[2], vals[3], acc);
        checks++;
        if (acc !== 4) begin
            errors++; $display("FAIL basic_accepts got=%0d want=4", acc);
        end
        checks++;
        if (fft_start !== 1'b0) begin
            errors++; $display("FAIL basic_start_early got=%b want=0 at t+1", fft_start);
        end
        tick();
        checks++;
        if (fft_start !== 1'b1) begin
            errors++; $display("FAIL basic_start_latency got=%b want=1 at t+2", fft_start);
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (frame_out[s] !== vals[slot_src(s)]) begin
                errors++; $display("FAIL basic_frame_out[%0d] got=%h want=%h", s, frame_out[s],
                                   vals[slot_src(s)]);
            end
        end
        fft_status = 1'b1;
        tick();
        checks++;
        if (fft_start !== 1'b0) begin
            errors++; $display("FAIL basic_start_single got=%b want=0", fft_start);
        end
        tick();
        checks++;
        if ({fft_reset, frame_done} !== 2'b11) begin
            errors++; $display("FAIL basic_release got=%b want=11", {fft_reset, frame_done});
        end
        fft_status = 1'b0;
        tick();
        checks++;
        if (frame_count !== 4'd1 || fft_reset !== 1'b0) begin
            errors++; $display("FAIL basic_count got=%0d/%b want=1/0", frame_count, fft_reset);
        end
    endtask

    task automatic test_handshake();
        int acc;
        int starts;
        apply_reset();
        acc    = 0;
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            s_valid = (acc < 12);
            s_data  = 32'h5000_0000 + 32'(acc);
            if (s_valid && s_ready) acc++;
            if (fft_start) starts++;
            tick();
        end
        checks++;
        if (acc !== 8) begin
            errors++; $display("FAIL hs_accepts got=%0d want=8", acc);
        end
        checks++;
        if (starts !== 1) begin
            errors++; $display("FAIL hs_starts got=%0d want=1", starts);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL hs_backpressure got=%b want=0", s_ready);
        end
        fft_status = 1'b1;
        tick();
        checks++;
        if ({fft_reset, frame_done, s_ready} !== 3'b110) begin
            errors++; $display("FAIL hs_release got=%b want=110", {fft_reset, frame_done, s_ready});
        end
        fft_status = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL hs_ready_return got=%b want=1", s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_ping_pong();
        int done, starts, bad, sent;
        apply_reset();
        run_stream(40, 3, done, starts, bad, sent);
        checks++;
        if (done !== 10 || starts !== 10) begin
            errors++; $display("FAIL pp_frames got=%0d/%0d want=10/10", done, starts);
        end
        checks++;
        if (frame_count !== 4'd10) begin
            errors++; $display("FAIL pp_count got=%0d want=10", frame_count);
        end
        checks++;
        if (bad !== 0 || sent !== 40) begin
            errors++; $display("FAIL pp_data got=bad%0d sent%0d want=bad0 sent40", bad, sent);
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        int cyc;
        apply_reset();
        for (int c = 0; c < 10 && acc < 2; c++) begin
            if (c == 0) acc = 0;
            s_valid = 1'b1;
            s_data  = 32'hBAD0_0000 + 32'(acc);
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        checks++;
        if ({s_ready, fft_start, fft_reset, frame_done} !== 4'b0000 || frame_count !== '0 ||
            frame_out !== '0) begin
            errors++; $display("FAIL midreset_outputs got=%b cnt=%0d fo=%h want=0000 0 0",
                               {s_ready, fft_start, fft_reset, frame_done}, frame_count,
                               frame_out);
        end
        reset_n = 1'b1;
        tick();
        send4(32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, acc);
        wait_start(cyc);
        checks++;
        if (cyc < 0) begin
            errors++; $display("FAIL midreset_start got=timeout want=start");
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (frame_out[s] !== 32'h0000_00A0 + 32'(slot_src(s))) begin
                errors++; $display("FAIL midreset_frame[%0d] got=%h want=%h", s, frame_out[s],
                                   32'h0000_00A0 + 32'(slot_src(s)));
            end
        end
    endtask

    task automatic test_bitrev();
        logic [3:0][WIDTH-1:0] exp;
        int acc;
        int cyc;
        apply_reset();
`ifdef FFT_LOADER_BITREV_EN
        exp = {32'd13, 32'd11, 32'd12, 32'd10};
`else
        exp = {32'd13, 32'd12, 32'd11, 32'd10};
`endif
        send4(32'd10, 32'd11, 32'd12, 32'd13, acc);
        wait_start(cyc);
        checks++;
        if (cyc !== 1) begin
            errors++; $display("FAIL order_start_cycle got=%0d want=1", cyc);
        end
        checks++;
        if (frame_out !== exp) begin
            errors++; $display("FAIL order_frame got=%h want=%h", frame_out, exp);
        end
    endtask

    task automatic test_wrap();
        int done, starts, bad, sent;
        apply_reset();
        run_stream(68, 2, done, starts, bad, sent);
        checks++;
        if (done !== 17) begin
            errors++; $display("FAIL wrap_frames got=%0d want=17", done);
        end
        checks++;
        if (frame_count !== 4'd1) begin
            errors++; $display("FAIL wrap_count got=%0d want=1", frame_count);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wrap_data got=%0d want=0", bad);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        fft_status = 1'b0;
        test_reset();
        test_basic_frame();
        test_handshake();
        test_ping_pong();
        test_reset_mid_frame();
        test_bitrev();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
